// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per step and issues it to decode.
// Optional retire counter on the RetireCount port when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | one cycle after reset release
// FETCH | request presented, waiting for memory to accept it
// WAIT  | request accepted, waiting for response (timeout armed)
// ISSUE | instruction valid to decode, waiting for NextPC
// HALT  | misaligned target or timeout; only reset exits
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          TIMEOUT  = 16,
  parameter int          TMR_W    = 8
) (
  input  logic        CLK,
  input  logic        resetl,
  output logic        IMemReqValid,
  input  logic        IMemReqReady,
  output logic [63:0] IMemAddr,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic        InstrValid,
  output logic [31:0] Instruction,
  output logic [63:0] CurrentPC,
  input  logic [63:0] NextPC,
  input  logic        NextPCValid,
  output logic        Fault,
  output logic [1:0]  FaultCause
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] RetireCount
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ISSUE = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // Last WAIT cycle index before a timeout fires; unused when TIMEOUT is 0.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [2:0]       state;
  logic [63:0]      pc;
  logic [TMR_W-1:0] timer;

  assign IMemAddr = pc;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      RetireCount <= 32'd0;
    end else if (state == ISSUE && NextPCValid && NextPC[1:0] == 2'b00) begin
      RetireCount <= RetireCount + 32'd1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      CurrentPC    <= RESET_PC;
      IMemReqValid <= 1'b0;
      InstrValid   <= 1'b0;
      Fault        <= 1'b0;
      FaultCause   <= 2'b00;
      Instruction  <= 32'd0;
      timer        <= '0;
    end else begin
      case (state)
        IDLE: begin
          state        <= FETCH;
          IMemReqValid <= 1'b1;
        end
        FETCH: begin
          if (IMemReqReady) begin
            state        <= WAIT;
            IMemReqValid <= 1'b0;
            timer        <= '0;
          end
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          // A response arriving on the timeout cycle takes priority.
          if (IMemRespValid) begin
            state       <= ISSUE;
            Instruction <= IMemRespData;
            CurrentPC   <= pc;
            InstrValid  <= 1'b1;
          end else if ((TIMEOUT != 0) && (timer == TMO_LAST)) begin
            state      <= HALT;
            Fault      <= 1'b1;
            FaultCause <= CAUSE_TIMEOUT;
          end
        end
        ISSUE: begin
          if (NextPCValid) begin
            InstrValid <= 1'b0;
            if (NextPC[1:0] == 2'b00) begin
              state        <= FETCH;
              pc           <= NextPC;
              IMemReqValid <= 1'b1;
            end else begin
              state      <= HALT;
              Fault      <= 1'b1;
              FaultCause <= CAUSE_MISALIGN;
            end
          end
        end
        HALT: begin
          IMemReqValid <= 1'b0;
          InstrValid   <= 1'b0;
          Fault        <= 1'b1;
        end
        default: begin
          state        <= HALT;
          IMemReqValid <= 1'b0;
          InstrValid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expectations.
// Define FETCH_PERF_CNT_EN to also check RetireCount.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        IMemReqValid;
  logic        IMemReqReady;
  logic [63:0] IMemAddr;
  logic        IMemRespValid;
  logic [31:0] IMemRespData;
  logic        InstrValid;
  logic [31:0] Instruction;
  logic [63:0] CurrentPC;
  logic [63:0] NextPC;
  logic        NextPCValid;
  logic        Fault;
  logic [1:0]  FaultCause;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] RetireCount;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int hs_cnt   = 0;
  int t_fetch0;
  int hs_before;

  pc_fetch_unit #(.RESET_PC(64'h0), .TIMEOUT(16), .TMR_W(8)) dut (
    .CLK          (CLK),
    .resetl       (resetl),
    .IMemReqValid (IMemReqValid),
    .IMemReqReady (IMemReqReady),
    .IMemAddr     (IMemAddr),
    .IMemRespValid(IMemRespValid),
    .IMemRespData (IMemRespData),
    .InstrValid   (InstrValid),
    .Instruction  (Instruction),
    .CurrentPC    (CurrentPC),
    .NextPC       (NextPC),
    .NextPCValid  (NextPCValid),
    .Fault        (Fault),
    .FaultCause   (FaultCause)
`ifdef FETCH_PERF_CNT_EN
    ,
    .RetireCount  (RetireCount)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (resetl && IMemReqValid && IMemReqReady) hs_cnt = hs_cnt + 1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetl        = 1'b0;
    IMemReqReady  = 1'b0;
    IMemRespValid = 1'b0;
    IMemRespData  = 32'd0;
    NextPC        = 64'd0;
    NextPCValid   = 1'b0;
    step(2);

    check("rst_req",     64'(IMemReqValid), 64'd0);
    check("rst_ivalid",  64'(InstrValid),   64'd0);
    check("rst_fault",   64'(Fault),        64'd0);
    check("rst_cause",   64'(FaultCause),   64'd0);
    check("rst_instr",   64'(Instruction),  64'd0);
    check("rst_curpc",   CurrentPC,         64'd0);
    check("rst_addr",    IMemAddr,          64'd0);

    resetl = 1'b1;
    step();
    check("idle_to_fetch_req", 64'(IMemReqValid), 64'd1);
    check("fetch0_addr",       IMemAddr,          64'd0);
    t_fetch0 = cyc;

    // Zero-wait loop at PC 0.
    IMemReqReady = 1'b1;
    step();
    check("t1_req_drop", 64'(IMemReqValid), 64'd0);
    IMemRespValid = 1'b1;
    IMemRespData  = 32'h8B020020;
    step();
    IMemRespValid = 1'b0;
    check("t1_ivalid", 64'(InstrValid),  64'd1);
    check("t1_instr",  64'(Instruction), 64'h8B020020);
    check("t1_curpc",  CurrentPC,        64'd0);
    NextPC      = 64'd4;
    NextPCValid = 1'b1;
    step();
    NextPCValid = 1'b0;
    check("t1_req_again",  64'(IMemReqValid),   64'd1);
    check("t1_addr4",      IMemAddr,            64'd4);
    check("t1_ivalid_off", 64'(InstrValid),     64'd0);
    check("t1_loop_cycles", 64'(cyc - t_fetch0), 64'd3);

    // Top-of-address-space target, then back to 0x40.
    step();
    IMemRespValid = 1'b1;
    IMemRespData  = 32'h11111111;
    step();
    IMemRespValid = 1'b0;
    check("wrap_instr", 64'(Instruction), 64'h11111111);
    NextPC      = 64'hFFFF_FFFF_FFFF_FFFC;
    NextPCValid = 1'b1;
    step();
    NextPCValid = 1'b0;
    check("wrap_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    IMemRespValid = 1'b1;
    IMemRespData  = 32'h22222222;
    step();
    IMemRespValid = 1'b0;
    check("wrap_curpc", CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
    NextPC       = 64'h40;
    NextPCValid  = 1'b1;
    IMemReqReady = 1'b0;
    step();

    // Backpressure at 0x40; stray response and misaligned strobe must be ignored.
    hs_before     = hs_cnt;
    IMemRespValid = 1'b1;
    IMemRespData  = 32'hDEADBEEF;
    NextPC        = 64'h3;
    NextPCValid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_held",  64'(IMemReqValid), 64'd1);
      check("t2_addr_held", IMemAddr,          64'h40);
      step();
    end
    IMemRespValid = 1'b0;
    NextPCValid   = 1'b0;
    check("t2_resp_ignored", 64'(Instruction), 64'h22222222);
    check("t2_npc_ignored",  64'(Fault),       64'd0);
    IMemReqReady = 1'b1;
    step();
    IMemReqReady = 1'b0;
    check("t2_req_drop",  64'(IMemReqValid),         64'd0);
    check("t2_one_accept", 64'(hs_cnt - hs_before), 64'd1);

    // Response on the last WAIT cycle beats the timeout.
    step(15);
    check("t4b_no_fault_early", 64'(Fault),      64'd0);
    check("t4b_still_wait",     64'(InstrValid), 64'd0);
    IMemRespValid = 1'b1;
    IMemRespData  = 32'h00000013;
    step();
    IMemRespValid = 1'b0;
    check("t4b_issue",    64'(InstrValid),  64'd1);
    check("t4b_no_fault", 64'(Fault),       64'd0);
    check("t4b_instr",    64'(Instruction), 64'h13);
    check("t4b_curpc",    CurrentPC,        64'h40);

    // Misaligned NextPC after an idle ISSUE cycle.
    step();
    check("t3_issue_hold", 64'(InstrValid), 64'd1);
    NextPC      = 64'h1002;
    NextPCValid = 1'b1;
    step();
    NextPCValid = 1'b0;
    check("t3_fault",   64'(Fault),        64'd1);
    check("t3_cause",   64'(FaultCause),   64'd1);
    check("t3_req",     64'(IMemReqValid), 64'd0);
    check("t3_ivalid",  64'(InstrValid),   64'd0);
    check("t3_curpc",   CurrentPC,         64'h40);
    check("t3_pc_kept", IMemAddr,          64'h40);
    IMemReqReady = 1'b1;
    step(3);
    IMemReqReady = 1'b0;
    check("t3_halt_req",   64'(IMemReqValid), 64'd0);
    check("t3_halt_fault", 64'(Fault),        64'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_retired", 64'(RetireCount), 64'd3);
`endif

    // Reset clears the halt asynchronously.
    resetl = 1'b0;
    #1;
    check("async_rst_fault", 64'(Fault), 64'd0);
    step();
    resetl = 1'b1;
    step();
    IMemReqReady = 1'b1;
    step();
    IMemReqReady = 1'b0;
    check("t5_in_wait", 64'(IMemReqValid), 64'd0);

    // Reset during WAIT, then a stale response during IDLE and FETCH.
    resetl = 1'b0;
    step();
    resetl        = 1'b1;
    IMemRespValid = 1'b1;
    IMemRespData  = 32'hBADBAD00;
    step();
    check("t5_addr",   IMemAddr,          64'd0);
    check("t5_req",    64'(IMemReqValid), 64'd1);
    check("t5_instr",  64'(Instruction),  64'd0);
    step();
    IMemRespValid = 1'b0;
    check("t5_instr_fetch", 64'(Instruction), 64'd0);
    check("t5_ivalid",      64'(InstrValid),  64'd0);

    // No response: timeout after 16 WAIT cycles.
    IMemReqReady = 1'b1;
    step();
    IMemReqReady = 1'b0;
    step(15);
    check("t4_no_fault_15", 64'(Fault), 64'd0);
    step();
    check("t4_fault", 64'(Fault),        64'd1);
    check("t4_cause", 64'(FaultCause),   64'd2);
    check("t4_req",   64'(IMemReqValid), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_after_reset", 64'(RetireCount), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
